uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ byte producers.
- Grants requesters round-robin and latches the winner's byte.
- Drives the UART send_req/send_ack handshake and returns a per-requester ack.
- Supports packet lock so multi-byte messages are not interleaved; a watchdog recovers from a missing UART ack or a stalled lock.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT_CYCLES, 1024, watchdog limit for UART ack wait and for lock idle time.
- ID_W (localparam), clog2(N_REQ), requester index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset; asserted when 0.
- req  in  N_REQ  per-requester byte-valid.
- req_data  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
- req_last  in  N_REQ  1 = last byte of packet; 0 = keep grant after this byte.
- req_ack  out  N_REQ  one-cycle pulse: byte accepted by UART.
- grant  out  N_REQ  one-hot current owner; 0 when idle.
- uart_data_in  out  8  byte to UART.
- uart_send_req  out  1  send request to UART.
- uart_send_ack  in  1  UART acceptance.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- timeout_id  out  ID_W  requester owning the grant at expiry; holds until next expiry.

Behaviour:
- Reset (async, reset=0) clears all outputs and internal state:
  - state=IDLE, rr_ptr=N_REQ-1 (requester 0 wins first), counter=0.
  - uart_send_req drops immediately; the in-flight byte is lost and no req_ack is issued.
- FSM states: IDLE, SEND, ACK, LOCKED.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning rr_ptr+1 upward with wrap.
  - Register grant, uart_data_in and the winner's req_last; go to SEND.
  - uart_send_req is high the cycle after req is sampled (latency 1).
- SEND:
  - uart_send_req=1; uart_data_in is held stable; counter increments each cycle.
  - uart_send_ack=1: go to ACK; uart_send_req is low from the next cycle.
  - counter reaches TIMEOUT_CYCLES-1 with no ack: pulse timeout_err, set timeout_id=winner, drop uart_send_req, clear grant, rr_ptr=winner, go to IDLE. No req_ack is issued.
  - Ack and timeout in the same cycle: ack wins.
- ACK:
  - Exactly one cycle; req_ack[winner]=1; req is not sampled.
  - Sets rr_ptr=winner and clears counter.
  - Latched last=1: clear grant, go to IDLE.
  - Latched last=0: keep grant, go to LOCKED.
- LOCKED:
  - Only req[winner] is considered; other requesters wait.
  - req[winner]=1: latch byte and last, go to SEND.
  - Otherwise counter increments; at TIMEOUT_CYCLES-1 pulse timeout_err, set timeout_id=winner, clear grant, go to IDLE.
- Requester protocol:
  - Hold req, data and last stable until req_ack is seen.
  - req still high in the cycle after req_ack is treated as a new byte.
  - Dropping req during SEND is a protocol violation; the latched byte is still sent.
- uart_send_ack outside SEND is ignored.
- Non-winning req bits stay pending and are never dropped by the arbiter.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- grant is always one-hot or zero. req_ack has at most one bit set, only in ACK.
- Throughput: a minimum of 3 cycles per byte (IDLE/LOCKED, SEND with immediate ack, ACK).

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, SEND, ACK, LOCKED};
  - the byte width constant (8);
  - the default TIMEOUT_CYCLES.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any_valid.
  - Reusable by other arbiters in the design.

Test Plan:
- Single requester: req[2]=1, data 0xA5, last=1, UART acks 3 cycles after send_req.
  - uart_send_req rises the cycle after req, with uart_data_in=0xA5.
  - Exactly one req_ack[2] pulse follows the ack; grant returns to 0.
- Fairness: req=4'b1111 held for 8 bytes, all last=1, UART acks immediately.
  - Grant order is 0,1,2,3,0,1,2,3; each requester gets exactly 2 req_ack pulses.
- Packet lock: requester 1 sends 3 bytes (last=0,0,1) while req[3]=1 throughout.
  - The three requester-1 bytes reach the UART consecutively; requester 3 is granted only after them.
- UART timeout: TIMEOUT_CYCLES=16, uart_send_ack tied 0, req[0]=1.
  - timeout_err pulses 16 cycles after send_req rises, timeout_id=0.
  - send_req drops, no req_ack is issued, and the arbiter re-arbitrates.
- Lock timeout: requester 2 sends last=0 then withdraws req; req[1]=1.
  - After 16 idle cycles timeout_err pulses with timeout_id=2.
  - Requester 1 is then granted.
- Async reset mid-SEND: reset=0 while uart_send_req=1.
  - uart_send_req, grant and req_ack go to 0 without waiting for a clock edge.
  - After release, requester 0 has priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned ByteW          = 8;
  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StAck,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr_i, with wrap.
module rr_pick #(
  parameter int unsigned  NReq = 4,
  localparam int unsigned IdW  = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdW-1:0]  rr_ptr_i,
  output logic [NReq-1:0] winner_oh_o,
  output logic [IdW-1:0]  winner_id_o,
  output logic            any_valid_o
);

  int unsigned    idx;
  logic [IdW-1:0] pick;

  always_comb begin
    winner_oh_o = '0;
    winner_id_o = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    pick        = '0;
    for (int unsigned k = 1; k <= NReq; k++) begin
      // rr_ptr_i < NReq and k <= NReq, so one subtraction is enough to wrap.
      idx = 32'(rr_ptr_i) + k;
      if (idx >= NReq) idx = idx - NReq;
      pick = IdW'(idx);
      if (!any_valid_o && req_i[pick]) begin
        any_valid_o       = 1'b1;
        winner_id_o       = pick;
        winner_oh_o[pick] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with packet lock and a watchdog on both the UART ack wait and the lock idle time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned  N_REQ          = 4,
  parameter int unsigned  TIMEOUT_CYCLES = DefaultTimeout,
  localparam int unsigned ID_W           = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [ByteW*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       grant,
  output logic [ByteW-1:0]       uart_data_in,
  output logic                   uart_send_req,
  input  logic                   uart_send_ack,
  output logic                   timeout_err,
  output logic [ID_W-1:0]        timeout_id
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ByteW-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic             timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]  timeout_id_q, timeout_id_d;

  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic [ByteW-1:0] req_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*ByteW +: ByteW];
  end

  rr_pick #(
    .NReq (N_REQ)
  ) u_rr_pick (
    .req_i       (req),
    .rr_ptr_i    (rr_ptr_q),
    .winner_oh_o (win_oh),
    .winner_id_o (win_id),
    .any_valid_o (win_valid)
  );

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    data_d        = data_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (win_valid) begin
          grant_d = win_oh;
          owner_d = win_id;
          data_d  = req_bytes[win_id];
          last_d  = req_last[win_id];
          state_d = StSend;
        end
      end
      StSend: begin
        // An ack in the expiry cycle still completes the byte.
        if (uart_send_ack) begin
          state_d = StAck;
        end else if (cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          timeout_id_d  = owner_q;
          grant_d       = '0;
          rr_ptr_d      = owner_q;
          cnt_d         = '0;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StAck: begin
        rr_ptr_d = owner_q;
        cnt_d    = '0;
        if (last_q) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (req[owner_q]) begin
          data_d  = req_bytes[owner_q];
          last_d  = req_last[owner_q];
          cnt_d   = '0;
          state_d = StSend;
        end else if (cnt_q == CntLast) begin
          timeout_err_d = 1'b1;
          timeout_id_d  = owner_q;
          grant_d       = '0;
          cnt_d         = '0;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      rr_ptr_q      <= ID_W'(N_REQ - 1);
      owner_q       <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      data_q        <= data_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

  assign uart_send_req = (state_q == StSend);
  assign uart_data_in  = data_q;
  assign grant         = grant_q;
  assign req_ack       = (state_q == StAck) ? grant_q : '0;
  assign timeout_err   = timeout_err_q;
  assign timeout_id    = timeout_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: scripted requesters, a UART responder and a transaction-level model
// of round-robin order, packet lock and byte delivery.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int T    = 16;
  localparam int MAXB = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     uart_data_in;
  logic           uart_send_req;
  logic           uart_send_ack;
  logic           timeout_err;
  logic [1:0]     timeout_id;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .uart_data_in  (uart_data_in),
    .uart_send_req (uart_send_req),
    .uart_send_ack (uart_send_ack),
    .timeout_err   (timeout_err),
    .timeout_id    (timeout_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester scripts: byte k of requester i, raised after s_gap idle cycles.
  logic [7:0] s_data [N][MAXB];
  logic       s_last [N][MAXB];
  int         s_gap  [N][MAXB];
  int         s_len  [N];
  int         pos    [N];
  int         gap_left [N];
  logic [N-1:0] ack_prev;

  bit ack_en;
  bit rand_delay;
  int fixed_delay;
  int wcnt;
  int cur_delay;

  int         last_owner;
  int         cur_owner;
  bit         locked_valid;
  int         locked_id;
  logic [N-1:0] prev_grant;
  logic [N-1:0] req_prev;
  logic [7:0] uart_byte;
  int         n_uart, n_acks, n_timeouts;
  int         ack_hist [$];
  logic [7:0] byte_hist [$];

  typedef struct {
    int         prime;
    logic [3:0] mask;
    int         exp_id;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // UART model: acks on the cur_delay-th cycle of send_req (0 = first cycle).
  initial begin
    uart_send_ack = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (uart_send_req && ack_en) begin
        if (wcnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 4)) : fixed_delay;
        uart_send_ack = (wcnt >= cur_delay);
        wcnt++;
      end else begin
        wcnt = 0;
        uart_send_ack = 1'b0;
      end
    end
  end

  task automatic clear_scripts();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 0;
      pos[i] = 0;
      gap_left[i] = 0;
    end
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input logic l, input int g);
    s_data[i][s_len[i]] = d;
    s_last[i][s_len[i]] = l;
    s_gap[i][s_len[i]]  = g;
    if (s_len[i] == 0) gap_left[i] = g;
    s_len[i]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (ack_prev[i] && pos[i] < s_len[i]) begin
        pos[i]++;
        if (pos[i] < s_len[i]) gap_left[i] = s_gap[i][pos[i]];
      end
      if (pos[i] < s_len[i]) begin
        if (gap_left[i] > 0) begin
          req[i] = 1'b0;
          gap_left[i]--;
        end else begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = s_data[i][pos[i]];
          req_last[i] = s_last[i][pos[i]];
        end
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic observe();
    int i;
    int e;
    if (uart_send_req && uart_send_ack) begin
      uart_byte = uart_data_in;
      n_uart++;
      byte_hist.push_back(uart_data_in);
    end
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (prev_grant == '0 && grant != '0) begin
      e = rr_first(req_prev, last_owner);
      check("rr_winner", 32'(grant), (e < 0) ? 32'd0 : 32'(1 << e));
      cur_owner = e;
    end
    if (timeout_err) begin
      n_timeouts++;
      check("timeout_id", 32'(timeout_id), 32'(cur_owner));
      check("timeout_grant", 32'(grant), 32'd0);
      last_owner = cur_owner;
      locked_valid = 1'b0;
    end
    if (locked_valid) check("lock_hold", 32'(grant), 32'(1 << locked_id));
    if (req_ack != '0) begin
      n_acks++;
      check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
      check("ack_is_grant", 32'(req_ack), 32'(grant));
      i = oh_idx(req_ack);
      ack_hist.push_back(i);
      if (locked_valid) check("lock_owner", 32'(i), 32'(locked_id));
      check("ack_pending", 32'(pos[i] < s_len[i]), 32'd1);
      if (pos[i] < s_len[i]) begin
        check("ack_byte", 32'(uart_byte), 32'(s_data[i][pos[i]]));
        locked_valid = !s_last[i][pos[i]];
        locked_id = i;
      end
      last_owner = i;
    end
    prev_grant = grant;
    req_prev = req;
    ack_prev = req_ack;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive_reqs();
    @(negedge clk);
    observe();
  endtask

  task automatic model_reset();
    last_owner = N - 1;
    cur_owner = 0;
    locked_valid = 1'b0;
    locked_id = 0;
    prev_grant = '0;
    req_prev = '0;
    ack_prev = '0;
    uart_byte = '0;
    n_uart = 0;
    n_acks = 0;
    n_timeouts = 0;
    ack_hist.delete();
    byte_hist.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    req_data = '0;
    req_last = '0;
    clear_scripts();
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_send_req", 32'(uart_send_req), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_timeout_id", 32'(timeout_id), 32'd0);
    check("rst_uart_data", 32'(uart_data_in), 32'd0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic run_until_acks(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (n_acks < n && c < budget) begin
      cycle();
      c++;
    end
    check(name, 32'(n_acks), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int total;
    int cnt [N];

    tbl[0] = '{prime: -1, mask: 4'b1111, exp_id: 0};
    tbl[1] = '{prime: -1, mask: 4'b1000, exp_id: 3};
    tbl[2] = '{prime: -1, mask: 4'b0110, exp_id: 1};
    tbl[3] = '{prime: 0,  mask: 4'b1111, exp_id: 1};
    tbl[4] = '{prime: 1,  mask: 4'b0001, exp_id: 0};
    tbl[5] = '{prime: 2,  mask: 4'b1011, exp_id: 3};
    tbl[6] = '{prime: 3,  mask: 4'b1110, exp_id: 1};
    tbl[7] = '{prime: 3,  mask: 4'b0101, exp_id: 0};
    tbl[8] = '{prime: 1,  mask: 4'b0101, exp_id: 2};
    tbl[9] = '{prime: 2,  mask: 4'b0011, exp_id: 0};

    ack_en = 1'b1;
    rand_delay = 1'b0;
    fixed_delay = 0;
    reset = 1'b0;
    req = '0;
    req_data = '0;
    req_last = '0;
    model_reset();

    // Single requester, UART acks 3 cycles after send_req.
    do_reset();
    fixed_delay = 3;
    add_byte(2, 8'hA5, 1'b1, 0);
    cycle();
    check("t1_send_req_c0", 32'(uart_send_req), 32'd0);
    cycle();
    check("t1_send_req_c1", 32'(uart_send_req), 32'd1);
    check("t1_uart_data", 32'(uart_data_in), 32'hA5);
    check("t1_grant", 32'(grant), 32'b0100);
    lat = 0;
    while (req_ack == '0 && lat < 20) begin
      cycle();
      lat++;
    end
    check("t1_ack_latency", 32'(lat), 32'd4);
    check("t1_req_ack", 32'(req_ack), 32'b0100);
    cycle();
    check("t1_ack_single", 32'(req_ack), 32'd0);
    check("t1_grant_idle", 32'(grant), 32'd0);
    check("t1_ack_count", 32'(n_acks), 32'd1);

    // Fairness with all four requesting.
    do_reset();
    fixed_delay = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) add_byte(i, 8'(16 * i + k), 1'b1, 0);
    run_until_acks(8, 60, "t2_acks_done");
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < ack_hist.size(); k++) begin
      if (k < 8) check("t2_order", 32'(ack_hist[k]), 32'(k % 4));
      cnt[ack_hist[k]]++;
    end
    for (int i = 0; i < N; i++) check("t2_per_req_acks", 32'(cnt[i]), 32'd2);

    // Packet lock: requester 1 sends three bytes while requester 3 waits.
    do_reset();
    add_byte(1, 8'hB0, 1'b0, 0);
    add_byte(1, 8'hB1, 1'b0, 0);
    add_byte(1, 8'hB2, 1'b1, 0);
    add_byte(3, 8'h33, 1'b1, 0);
    run_until_acks(4, 60, "t3_acks_done");
    if (byte_hist.size() >= 4) begin
      check("t3_byte0", 32'(byte_hist[0]), 32'hB0);
      check("t3_byte1", 32'(byte_hist[1]), 32'hB1);
      check("t3_byte2", 32'(byte_hist[2]), 32'hB2);
      check("t3_byte3", 32'(byte_hist[3]), 32'h33);
    end else begin
      check("t3_byte_count", 32'(byte_hist.size()), 32'd4);
    end

    // UART never acks: watchdog after T cycles of send_req.
    do_reset();
    ack_en = 1'b0;
    add_byte(0, 8'h5A, 1'b1, 0);
    cycle();
    cycle();
    check("t4_send_req", 32'(uart_send_req), 32'd1);
    lat = 0;
    while (!timeout_err && lat < 40) begin
      cycle();
      lat++;
    end
    check("t4_timeout_latency", 32'(lat), 32'(T));
    check("t4_timeout_id", 32'(timeout_id), 32'd0);
    check("t4_send_req_drop", 32'(uart_send_req), 32'd0);
    check("t4_no_ack", 32'(n_acks), 32'd0);
    cycle();
    check("t4_err_pulse", 32'(timeout_err), 32'd0);
    check("t4_id_hold", 32'(timeout_id), 32'd0);
    check("t4_rearb_grant", 32'(grant), 32'b0001);
    check("t4_rearb_send", 32'(uart_send_req), 32'd1);
    ack_en = 1'b1;
    run_until_acks(1, 20, "t4_drain");

    // Lock stalls: requester 2 leaves a packet open, requester 1 waits.
    do_reset();
    add_byte(2, 8'hC2, 1'b0, 0);
    add_byte(1, 8'h11, 1'b1, 2);
    lat = 0;
    while (req_ack[2] !== 1'b1 && lat < 10) begin
      cycle();
      lat++;
    end
    check("t5_first_ack", 32'(req_ack), 32'b0100);
    lat = 0;
    while (!timeout_err && lat < 40) begin
      cycle();
      lat++;
    end
    check("t5_timeout_latency", 32'(lat), 32'(T + 1));
    check("t5_timeout_id", 32'(timeout_id), 32'd2);
    check("t5_grant_cleared", 32'(grant), 32'd0);
    cycle();
    check("t5_next_grant", 32'(grant), 32'b0010);
    run_until_acks(2, 20, "t5_drain");

    // Asynchronous reset while a byte is in flight.
    do_reset();
    ack_en = 1'b0;
    add_byte(2, 8'h77, 1'b1, 0);
    cycle();
    cycle();
    check("t6_send_req_pre", 32'(uart_send_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_send_req", 32'(uart_send_req), 32'd0);
    check("t6_async_grant", 32'(grant), 32'd0);
    check("t6_async_req_ack", 32'(req_ack), 32'd0);
    ack_en = 1'b1;
    do_reset();
    for (int i = 0; i < N; i++) add_byte(i, 8'(8'hE0 + i), 1'b1, 0);
    cycle();
    cycle();
    check("t6_post_reset_grant", 32'(grant), 32'b0001);
    run_until_acks(4, 40, "t6_drain");

    // Arbitration table: prime rr_ptr with one byte, then present a request mask.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      fixed_delay = 0;
      if (tbl[v].prime >= 0) begin
        add_byte(tbl[v].prime, 8'h01, 1'b1, 0);
        run_until_acks(1, 10, "tbl_prime");
        cycle();
        clear_scripts();
      end
      for (int i = 0; i < N; i++)
        if (tbl[v].mask[i]) add_byte(i, 8'(8'h40 + i), 1'b1, 0);
      lat = 0;
      while (grant == '0 && lat < 5) begin
        cycle();
        lat++;
      end
      check("tbl_grant", 32'(grant), 32'(1 << tbl[v].exp_id));
      check("tbl_data", 32'(uart_data_in), 32'(8'h40 + tbl[v].exp_id));
    end

    // Randomised traffic against the transaction model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_delay = 1'b1;
      total = 0;
      for (int i = 0; i < N; i++) begin
        int len;
        len = int'($urandom_range(8, 16));
        for (int k = 0; k < len; k++)
          add_byte(i, 8'($urandom), (k == len - 1) ? 1'b1 : ($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)));
        total += len;
      end
      run_until_acks(total, 3000, "rand_all_acked");
      check("rand_no_timeout", 32'(n_timeouts), 32'd0);
      check("rand_uart_vs_acks", 32'(n_uart), 32'(n_acks));
      rand_delay = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
